// File: rtl/fir_ctrl.sv
// Sequencer for a 3-tap FIR datapath: tags real samples versus bubbles, collects results in a
// credit-protected output FIFO and applies shadowed coefficient updates via drain/load/flush.
module fir_ctrl #(
    parameter int WIDTH   = 8,
    parameter int FIR_LAT = 1,
    parameter int TAPS    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [2*WIDTH-1:0] m_data,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [WIDTH-1:0]   cfg_data,
    input  logic               cfg_commit,
    output logic               cfg_busy,
    output logic [WIDTH-1:0]   fir_in,
    output logic [WIDTH-1:0]   w_1,
    output logic [WIDTH-1:0]   w_2,
    output logic [WIDTH-1:0]   w_3,
    input  logic [2*WIDTH-1:0] fir_out
);

    localparam int DEPTH = FIR_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW    = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [CW:0]   CREDITS    = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(TAPS - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [FW-1:0]      flush_cnt_q;
    logic [WIDTH-1:0]   sh_1, sh_2, sh_3;
    logic [FIR_LAT-1:0] tag_q;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [CW:0]        credit_sum;

    logic accept, push, pop;

    assign accept = s_valid & s_ready;
    assign push   = tag_q[FIR_LAT-1];
    assign pop    = m_valid & m_ready;

    assign m_valid = (count_q != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        inflight_d = inflight_q;

        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;

        if (accept && !push)
            inflight_d = inflight_q + 1'b1;
        else if (!accept && push)
            inflight_d = inflight_q - 1'b1;

        unique case (state_q)
            RUN:     if (cfg_commit) state_d = DRAIN;
            DRAIN:   if (inflight_q == '0) state_d = LOAD;
            LOAD:    state_d = FLUSH;
            FLUSH:   if (flush_cnt_q == FLUSH_LAST) state_d = RUN;
            default: state_d = RUN;
        endcase

        credit_sum = {1'b0, count_d} + {1'b0, inflight_d};
    end

    // s_ready and cfg_busy are registered from next-state values so both read 0 during reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            s_ready     <= 1'b0;
            cfg_busy    <= 1'b0;
            fir_in      <= '0;
            tag_q       <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sh_1        <= '0;
            sh_2        <= '0;
            sh_3        <= '0;
            w_1         <= '0;
            w_2         <= '0;
            w_3         <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 1'b1 : '0;
            s_ready     <= (state_d == RUN) && (credit_sum < CREDITS);
            cfg_busy    <= (state_d != RUN);
            fir_in      <= accept ? s_data : '0;
            tag_q       <= (tag_q << 1) | FIR_LAT'(accept);
            inflight_q  <= inflight_d;
            count_q     <= count_d;

            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);

            if (cfg_we) begin
                unique case (cfg_addr)
                    2'd0:    sh_1 <= cfg_data;
                    2'd1:    sh_2 <= cfg_data;
                    2'd2:    sh_3 <= cfg_data;
                    default: ;
                endcase
            end

            if (state_q == LOAD) begin
                w_1 <= sh_1;
                w_2 <= sh_2;
                w_3 <= sh_3;
            end
        end
    end

    // NOTE: FIFO storage has no reset; occupancy is reset and m_data is gated when empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fir_out;
    end

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with a behavioural 3-tap filter and a queue-based scoreboard
// whose expected results come from a golden history of accepted samples and bubble zeros.
module tb_fir_ctrl;

    localparam int WIDTH   = 8;
    localparam int FIR_LAT = 1;
    localparam int TAPS    = 3;
    localparam int GAP_MAX = FIR_LAT + TAPS + 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               s_valid, s_ready;
    logic [WIDTH-1:0]   s_data;
    logic               m_valid, m_ready;
    logic [2*WIDTH-1:0] m_data;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [WIDTH-1:0]   cfg_data;
    logic               cfg_commit, cfg_busy;
    logic [WIDTH-1:0]   fir_in, w_1, w_2, w_3;
    logic [2*WIDTH-1:0] fir_out;

    fir_ctrl #(.WIDTH(WIDTH), .FIR_LAT(FIR_LAT), .TAPS(TAPS)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
        .fir_in(fir_in), .w_1(w_1), .w_2(w_2), .w_3(w_3),
        .fir_out(fir_out)
    );

    always #5 clk = ~clk;

    // Behavioural filter: combinational sum over a free-running delay line (one-cycle latency).
    logic [WIDTH-1:0] d1 = '0, d2 = '0;
    always @(posedge clk) begin
        d1 <= fir_in;
        d2 <= d1;
    end
    assign fir_out = 16'(w_1) * 16'(fir_in) + 16'(w_2) * 16'(d1) + 16'(w_3) * 16'(d2);

    int n_pass  = 0;
    int n_total = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;

    logic [2*WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0]   sh [3];
    logic [WIDTH-1:0]   mw [3];
    logic [WIDTH-1:0]   h0, h1, h2;
    logic               hold_valid;
    logic [2*WIDTH-1:0] hold_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: each handshake seen before an edge pushes its golden result; pops compare.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) begin
                h2 = h1; h1 = h0; h0 = s_data;
                exp_q.push_back(16'(mw[0]) * 16'(h0) + 16'(mw[1]) * 16'(h1) + 16'(mw[2]) * 16'(h2));
                acc_cnt++;
            end else begin
                h2 = h1; h1 = h0; h0 = '0;
            end
            if (hold_valid) begin
                check("m_valid_hold", m_valid, 1);
                check("m_data_hold", m_data, hold_data);
            end
            hold_valid = m_valid && !m_ready;
            hold_data  = m_data;
            if (m_valid && m_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) check("sb_extra_result", 32'(exp_q.size()), 1);
                else check("sb_result", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        h0 = '0; h1 = '0; h2 = '0;
        hold_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin sh[i] = '0; mw[i] = '0; end
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [WIDTH-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        cycle();
        cfg_we = 1'b0;
        if (a != 2'd3) sh[a] = d;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (cfg_busy && t < 50) begin cycle(); t++; end
        check(tag, cfg_busy, 0);
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        cycle();
        cfg_commit = 1'b0;
        mw = sh;
        check("busy_set", cfg_busy, 1);
        wait_idle("busy_clear");
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        int t = 0;
        s_valid = 1'b1; s_data = d;
        while (!s_ready && t < 50) begin cycle(); t++; end
        check("send_ready", s_ready, 1);
        cycle();
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 100) begin cycle(); t++; end
        check({tag, "_queue"}, 32'(exp_q.size()), 0);
        check({tag, "_m_valid"}, m_valid, 0);
    endtask

    initial begin
        int acc0, pop0, low, busy_seen;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        clear_model();
        repeat (3) cycle();

        // Reset values
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_fir_in", fir_in, 0);
        check("rst_w", {w_1, w_2, w_3}, 0);
        rst_n = 1'b1;
        cycle();
        check("run_s_ready", s_ready, 1);

        // Load (0x5B, 0xFF, 0x87) and send one sample
        cfg_write(2'd0, 8'h5B);
        cfg_write(2'd1, 8'hFF);
        cfg_write(2'd2, 8'h87);
        commit();
        check("w_loaded", {w_1, w_2, w_3}, 24'h5BFF87);
        pop0 = pop_cnt;
        send(8'hFF);
        s_valid = 1'b0;
        check("first_fir_in", fir_in, 8'hFF);
        cycle();
        check("first_m_valid", m_valid, 1);
        check("first_m_data", m_data, 16'h5AA5);
        repeat (4) cycle();
        check("bubbles_dropped", pop_cnt - pop0, 1);

        // Back-to-back samples through the golden history
        send(8'hFF); send(8'h00); send(8'hFF);
        s_valid = 1'b0;
        wait_drain("burst");

        // Backpressure: exactly FIR_LAT+2 accepted
        m_ready = 1'b0;
        acc0 = acc_cnt; pop0 = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = WIDTH'(8'h10 + i);
            cycle();
        end
        check("bp_accepts", acc_cnt - acc0, FIR_LAT + 2);
        check("bp_s_ready", s_ready, 0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_drain("bp");
        check("bp_pops", pop_cnt - pop0, FIR_LAT + 2);

        // Commit (1,0,0) under continuous traffic
        cfg_write(2'd0, 8'd1); cfg_write(2'd1, 8'd0); cfg_write(2'd2, 8'd0);
        low = 0;
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1; s_data = WIDTH'($urandom);
            if (i == 5) cfg_commit = 1'b1;
            cycle();
            if (i == 5) begin cfg_commit = 1'b0; mw = sh; end
            if (i >= 5 && !s_ready) low++;
        end
        s_valid = 1'b0;
        check("commit_gap_ok", (low > 0 && low <= GAP_MAX), 1);
        check("commit_w", {w_1, w_2, w_3}, 24'h010000);
        wait_drain("commit");

        // Ignored commands: addr 3 write, same-cycle write+commit, commit while busy
        cfg_write(2'd3, 8'h77);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd2; cfg_commit = 1'b1;
        cycle();
        cfg_we = 1'b0; cfg_commit = 1'b0;
        sh[0] = 8'd2; mw = sh;
        check("busy_after_commit", cfg_busy, 1);
        cfg_commit = 1'b1;
        cycle();
        cfg_commit = 1'b0;
        wait_idle("busy_clear2");
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin cycle(); if (cfg_busy) busy_seen++; end
        check("busy_commit_ignored", busy_seen, 0);
        check("w_after_ignored", {w_1, w_2, w_3}, 24'h020000);
        for (int i = 0; i < 4; i++) send(WIDTH'(8'h30 + i));
        s_valid = 1'b0;
        wait_drain("scaled");

        // Async reset during DRAIN
        s_valid = 1'b1; s_data = 8'hA5; cfg_commit = 1'b1;
        cycle();
        s_valid = 1'b0; cfg_commit = 1'b0;
        check("drain_busy", cfg_busy, 1);
        check("drain_s_ready", s_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        clear_model();
        check("arst_s_ready", s_ready, 0);
        check("arst_m_valid", m_valid, 0);
        check("arst_m_data", m_data, 0);
        check("arst_cfg_busy", cfg_busy, 0);
        check("arst_fir_in", fir_in, 0);
        check("arst_w", {w_1, w_2, w_3}, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_busy", cfg_busy, 0);
        send(8'h42);
        s_valid = 1'b0;
        wait_drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
